uart_rx_deser: RTL and testbench



---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_sync2.sv | 25 ++
 rtl/uart_rx_deser.sv | 165 ++++++++++++++++
 tb/tb_uart_rx_deser.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width and FSM state encoding used by RX and TX.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    localparam logic [2:0] IDLE   = 3'b000;
    localparam logic [2:0] START  = 3'b001;
    localparam logic [2:0] DATA   = 3'b010;
    localparam logic [2:0] PARITY = 3'b011;
    localparam logic [2:0] STOP   = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE   = IDLE,
        ST_START  = START,
        ST_DATA   = DATA,
        ST_PARITY = PARITY,
        ST_STOP   = STOP
    } uart_state_e;

    // XOR of all data bits; an even-parity frame carries this value as its parity bit.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an idle-high asynchronous input; both flops reset to 1.
module uart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Capture the async line and retime it through a second flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_deser.sv
// Oversampling UART receiver: 8N1 / 8E1 frames to a valid/ready byte port with error flags.
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16,
    parameter bit          PARITY_EN  = 1'b1
) (
    input  logic                 clk_uart,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    logic rx_s;

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic                 rx_prev_q;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 data_valid_q, data_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q, busy_d;
    logic                 complete;

    // Bring the asynchronous serial line into the clk_uart domain.
    uart_sync2 u_sync (
        .clk   (clk_uart),
        .rst_n (rst),
        .d     (rx),
        .q     (rx_s)
    );

    // State and output registers.
    always_ff @(posedge clk_uart or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            rx_prev_q    <= 1'b1;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            rx_prev_q    <= rx_s;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end

    // Frame sequencing, bit-centre sampling and output handshake.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;
        complete     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // Only a genuine 1->0 transition starts a frame; a stuck-low line does not.
                if (rx_prev_q && !rx_s) begin
                    state_d = ST_START;
                    idx_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d     = '0;
                    par_bit_d = rx_s;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                    complete = 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // A completing frame replaces the held byte only if the slot is free or being accepted.
        if (complete) begin
            if (!data_valid_q || data_ready) begin
                data_out_d   = shift_q;
                parity_err_d = PARITY_EN ? (par_bit_q != even_parity(shift_q)) : 1'b0;
                frame_err_d  = ~rx_s;
                data_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (data_valid_q && data_ready) begin
            data_valid_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed and randomized frames against a line-level reference model of uart_rx_deser.
module tb_uart_rx_deser;

    localparam int unsigned OS  = 16;
    localparam bit          PEN = 1'b1;
    localparam int          LAT = 2 + (9 + int'(PEN)) * int'(OS) + int'(OS) / 2 + 1;
    localparam int          FALSE_START_DROP = 2 + int'(OS) / 2 + 1;

    logic       clk_uart;
    logic       rst;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx_deser #(.OVERSAMPLE(OS), .PARITY_EN(PEN)) dut (
        .clk_uart   (clk_uart),
        .rst        (rst),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial clk_uart = 1'b0;
    always #5 clk_uart = ~clk_uart;

    int checks = 0;
    int errors = 0;

    // Observation state, updated shortly after each rising edge.
    int         cyc = 0;
    int         rise_cnt = 0;
    int         rise_cyc = 0;
    int         dv_width = 0;
    int         busy_fall_cyc = 0;
    int         ovr_cycles = 0;
    logic       dv_prev = 1'b0;
    logic       busy_prev = 1'b0;
    logic [7:0] cap_data = 8'h00;
    logic       cap_perr = 1'b0;
    logic       cap_ferr = 1'b0;

    always @(posedge clk_uart) begin
        cyc++;
        #2;
        if (data_valid && !dv_prev) begin
            rise_cnt++;
            rise_cyc = cyc;
            cap_data = data_out;
            cap_perr = parity_err;
            cap_ferr = frame_err;
        end
        if (!data_valid && dv_prev) dv_width = cyc - rise_cyc;
        if (!busy && busy_prev) busy_fall_cyc = cyc;
        if (overrun) ovr_cycles++;
        dv_prev   = data_valid;
        busy_prev = busy;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive up to nbits bits of a frame, one bit per OS cycles, starting at the current negedge.
    task automatic send_frame(input logic [7:0] b, input logic pbit, input logic stop_v, input int nbits);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
        if (PEN) bits.push_back(pbit);
        bits.push_back(stop_v);
        for (int k = 0; k < bits.size() && k < nbits; k++) begin
            rx = bits[k];
            repeat (OS) @(negedge clk_uart);
        end
    endtask

    // Compare the byte captured at data_valid's rise against what the line carried.
    task automatic check_frame(input string tag, input logic [7:0] b, input logic pbit,
                               input logic stop_v, input int start, input int rc0);
        logic exp_perr;
        exp_perr = PEN ? (pbit != (^b)) : 1'b0;
        chk({tag, " count"},     32'(rise_cnt - rc0), 32'd1);
        chk({tag, " latency"},   32'(rise_cyc - start), 32'(LAT));
        chk({tag, " data"},      32'(cap_data), 32'(b));
        chk({tag, " parity"},    32'(cap_perr), 32'(exp_perr));
        chk({tag, " frame"},     32'(cap_ferr), 32'(!stop_v));
        chk({tag, " dv width"},  32'(dv_width), 32'd1);
        chk({tag, " busy fall"}, 32'(busy_fall_cyc), 32'(rise_cyc));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " data_out"},   32'(data_out), 32'h0);
        chk({tag, " data_valid"}, 32'(data_valid), 32'h0);
        chk({tag, " parity_err"}, 32'(parity_err), 32'h0);
        chk({tag, " frame_err"},  32'(frame_err), 32'h0);
        chk({tag, " overrun"},    32'(overrun), 32'h0);
        chk({tag, " busy"},       32'(busy), 32'h0);
    endtask

    initial begin
        logic [7:0] b;
        logic       pbit;
        logic       stop_v;
        int         st;
        int         rc0;
        int         ov0;

        rst        = 1'b0;
        rx         = 1'b1;
        data_ready = 1'b1;
        repeat (3) @(negedge clk_uart);
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (5) @(negedge clk_uart);

        // 0xA5, correct parity, good stop.
        b = 8'hA5; pbit = ^b; stop_v = 1'b1;
        rc0 = rise_cnt; st = cyc;
        send_frame(b, pbit, stop_v, 99);
        check_frame("a5", b, pbit, stop_v, st, rc0);

        // 0x3C with the parity bit inverted.
        rx = 1'b1; repeat (4) @(negedge clk_uart);
        b = 8'h3C; pbit = ~(^b); stop_v = 1'b1;
        rc0 = rise_cnt; st = cyc;
        send_frame(b, pbit, stop_v, 99);
        check_frame("3c badpar", b, pbit, stop_v, st, rc0);

        // 0xFF with a low stop bit, then the line stays low.
        rx = 1'b1; repeat (4) @(negedge clk_uart);
        b = 8'hFF; pbit = ^b; stop_v = 1'b0;
        rc0 = rise_cnt; st = cyc;
        send_frame(b, pbit, stop_v, 99);
        check_frame("ff badstop", b, pbit, stop_v, st, rc0);
        repeat (40) @(negedge clk_uart);
        chk("held low no retrigger", 32'(rise_cnt - rc0), 32'd1);
        chk("held low busy", 32'(busy), 32'd0);

        rx = 1'b1; repeat (4) @(negedge clk_uart);
        b = 8'h00; pbit = ^b; stop_v = 1'b1;
        rc0 = rise_cnt; st = cyc;
        send_frame(b, pbit, stop_v, 99);
        check_frame("00 after ferr", b, pbit, stop_v, st, rc0);

        // False start: a 4-cycle low glitch.
        rx = 1'b1; repeat (4) @(negedge clk_uart);
        rc0 = rise_cnt; ov0 = ovr_cycles; st = cyc;
        rx = 1'b0;
        repeat (4) @(negedge clk_uart);
        rx = 1'b1;
        chk("false start busy high", 32'(busy), 32'd1);
        repeat (30) @(negedge clk_uart);
        chk("false start busy drop", 32'(busy_fall_cyc - st), 32'(FALSE_START_DROP));
        chk("false start no byte", 32'(rise_cnt - rc0), 32'd0);
        chk("false start no overrun", 32'(ovr_cycles - ov0), 32'd0);
        chk("false start parity", 32'(parity_err), 32'd0);
        chk("false start frame", 32'(frame_err), 32'd0);
        chk("false start busy", 32'(busy), 32'd0);

        // Consumer stalled across two back-to-back frames.
        data_ready = 1'b0;
        rc0 = rise_cnt; ov0 = ovr_cycles;
        send_frame(8'h11, ^(8'h11), 1'b1, 99);
        send_frame(8'h22, ^(8'h22), 1'b1, 99);
        chk("ovr data held", 32'(data_out), 32'h11);
        chk("ovr valid held", 32'(data_valid), 32'd1);
        chk("ovr first byte", 32'(cap_data), 32'h11);
        chk("ovr rises", 32'(rise_cnt - rc0), 32'd1);
        chk("ovr pulse", 32'(ovr_cycles - ov0), 32'd1);
        data_ready = 1'b1;
        @(negedge clk_uart);
        chk("ovr accept clears", 32'(data_valid), 32'd0);
        chk("ovr data after accept", 32'(data_out), 32'h11);
        repeat (20) @(negedge clk_uart);
        chk("ovr 22 never shown", 32'(rise_cnt - rc0), 32'd1);

        // Reset during data bit 4 of 0x5A.
        rc0 = rise_cnt;
        b = 8'h5A;
        send_frame(b, ^b, 1'b1, 5);
        rx = b[4];
        repeat (OS / 2) @(negedge clk_uart);
        chk("midreset busy before", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset async");
        rx = 1'b1;
        repeat (5) @(negedge clk_uart);
        rst = 1'b1;
        repeat (200) @(negedge clk_uart);
        check_reset_outputs("midreset after");
        chk("midreset no byte", 32'(rise_cnt - rc0), 32'd0);

        b = 8'hC3; pbit = ^b; stop_v = 1'b1;
        rc0 = rise_cnt; st = cyc;
        send_frame(b, pbit, stop_v, 99);
        check_frame("c3 after reset", b, pbit, stop_v, st, rc0);

        // Randomized frames with occasional parity and stop errors.
        for (int k = 0; k < 16; k++) begin
            b      = 8'($urandom);
            pbit   = (^b) ^ ($urandom_range(0, 3) == 0);
            stop_v = ($urandom_range(0, 4) != 0);
            rx = 1'b1;
            repeat ($urandom_range(2, 6)) @(negedge clk_uart);
            rc0 = rise_cnt; st = cyc;
            send_frame(b, pbit, stop_v, 99);
            check_frame("rnd", b, pbit, stop_v, st, rc0);
        end

        rx = 1'b1;
        repeat (10) @(negedge clk_uart);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
